mem_access_arbiter: RTL

- Sequences every access to the single-port unified LC-3 memory and shares that memory between two requesters: the CPU memory interface and a program loader/debug port.
- CPU side: MIO_EN, R.W, MAR and MDR drive the CPU request; the block returns the READY bit consumed by the microsequencer.
- The block issues one-cycle requests to a synchronous-read SRAM and waits a fixed latency before answering.
- Round-robin arbitration keeps the loader from starving the CPU, and the CPU from starving the loader.

---
 rtl/mem_access_arbiter.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter: shares the single-port LC-3 memory between the CPU memory
// interface and the loader/debug port. Each grant issues a one-cycle request to a
// synchronous-read SRAM and waits MEM_LAT cycles. The winner then gets a one-cycle
// completion pulse. Ties are broken round-robin against the last winner.
module mem_access_arbiter #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned MEM_LAT = 3
) (
  input  logic              clk,
  input  logic              reset,
  // CPU side
  input  logic              cpu_mio_en,
  input  logic              cpu_r_w,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              ready_bit,
  // Loader side
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              ld_ack,
  // SRAM side
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  // Status
  output logic              busy,
  output logic              owner
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Counter load value; MEM_LAT <= 15 keeps it within 4 bits.
  localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);

  if (MEM_LAT < 2 || MEM_LAT > 15) begin : gen_bad_mem_lat
    $error("mem_access_arbiter: MEM_LAT must be in 2..15");
  end

  logic [1:0]        state_q, state_d;
  logic [3:0]        wait_cnt_q, wait_cnt_d;
  logic              last_grant_q, last_grant_d;
  logic              owner_q, owner_d;
  logic              busy_q, busy_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] ld_rdata_q, ld_rdata_d;
  logic              ready_q, ready_d;
  logic              ld_ack_q, ld_ack_d;

  logic grant_any;
  logic grant_ld;

  // Pick a winner: a lone requester wins, a tie goes to whoever was not served last.
  always_comb begin
    grant_any = cpu_mio_en | ld_req;
    grant_ld  = ld_req & (~cpu_mio_en | ~last_grant_q);
  end

  // Next-state and registered-output logic for IDLE -> ACC -> DONE -> IDLE.
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    mem_en_d     = 1'b0;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    cpu_rdata_d  = cpu_rdata_q;
    ld_rdata_d   = ld_rdata_q;
    ready_d      = 1'b0;
    ld_ack_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_any) begin
          mem_en_d     = 1'b1;
          mem_we_d     = grant_ld ? ld_we : cpu_r_w;
          mem_addr_d   = grant_ld ? ld_addr : cpu_addr;
          mem_wdata_d  = grant_ld ? ld_wdata : cpu_wdata;
          owner_d      = grant_ld;
          last_grant_d = grant_ld;
          wait_cnt_d   = LAT_LOAD;
          state_d      = ACC;
        end
      end
      ACC: begin
        // Write enable only accompanies the single mem_en cycle.
        mem_we_d = 1'b0;
        if (wait_cnt_q == 4'd0) begin
          if (owner_q) begin
            ld_rdata_d = mem_rdata;
            ld_ack_d   = 1'b1;
          end else begin
            cpu_rdata_d = mem_rdata;
            ready_d     = 1'b1;
          end
          state_d = DONE;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      DONE: begin
        // Dead cycle so a still-held request is not re-granted as a new one.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset abandons any access in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      wait_cnt_q   <= 4'd0;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      busy_q       <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cpu_rdata_q  <= '0;
      ld_rdata_q   <= '0;
      ready_q      <= 1'b0;
      ld_ack_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      busy_q       <= busy_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
      ld_rdata_q   <= ld_rdata_d;
      ready_q      <= ready_d;
      ld_ack_q     <= ld_ack_d;
    end
  end

  assign cpu_rdata = cpu_rdata_q;
  assign ready_bit = ready_q;
  assign ld_rdata  = ld_rdata_q;
  assign ld_ack    = ld_ack_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign owner     = owner_q;

endmodule
